// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and defaults for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 3;
  localparam int SRAM_DATA_W = 32;
  localparam int DEPTH       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RSP     = 3'd4,
    INIT    = 3'd5
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_req_ctrl.sv
// Request-side controller for the 8x32 DFF SRAM: serialises single-beat
// read/write requests onto add/we/wd and returns read data on a response
// channel. The SRAM latches its read address on any edge where we=0, so a
// read spends one cycle presenting the address and one cycle capturing rd.
// Optional build macro SRAM_INIT_EN: after reset, sweep INIT_VAL into every
// word before accepting requests.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; sram_add holds its last value
// WR      | write strobe high, SRAM captures wd at the exiting edge
// RD_ADDR | we=0 with the read address; SRAM latches it at exit edge
// RD_CAP  | sram_rd valid, captured into rsp_rdata at exit edge
// RSP     | rsp_valid held until rsp_ready
// INIT    | fill sweep, one word per cycle (SRAM_INIT_EN only)
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = SRAM_ADDR_W,
  parameter int          DATA_W   = SRAM_DATA_W,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_add,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wd,
  input  logic [DATA_W-1:0] sram_rd,
  output logic              busy
);

  // A fill value wider than the data path would be silently truncated.
  if (DATA_W < 32 && (INIT_VAL >> DATA_W) != 32'h0) begin : g_bad_init_val
    $error("INIT_VAL does not fit in DATA_W bits");
  end

`ifdef SRAM_INIT_EN
  localparam state_t            RESET_STATE = INIT;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam logic [DATA_W-1:0] FILL        = DATA_W'(INIT_VAL);
`else
  localparam state_t            RESET_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    state_d     = state_q;
    add_d       = add_q;
    wd_d        = wd_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          add_d   = req_addr;
          wd_d    = req_wdata;
          state_d = req_write ? WR : RD_ADDR;
        end
      end
      WR:      state_d = IDLE;
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d     = sram_rd;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef SRAM_INIT_EN
      INIT: begin
        if (add_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          add_d = add_q + ADDR_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RESET_STATE;
      add_q       <= '0;
      wd_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      add_q       <= add_d;
      wd_q        <= wd_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_add  = add_q;
`ifdef SRAM_INIT_EN
  assign sram_we   = (state_q == WR) || (state_q == INIT);
  assign sram_wd   = (state_q == INIT) ? FILL : wd_q;
`else
  assign sram_we   = (state_q == WR);
  assign sram_wd   = wd_q;
`endif

endmodule
